// File: rtl/fetch_queue.sv
// Instruction-fetch stage: sequential imem reads into a DEPTH-entry {pc, instr} FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN: forces redirect targets even and flags odd ones.
module fetch_queue #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] ir_pc,
  output logic             misaligned
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] squash_addr_q, squash_addr_d;
  logic [CW-1:0]    count_q, count_d, count_if_push;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic             push, pop;
  logic [WIDTH-1:0] target_pc;
  logic             imem_read_d;
  logic [WIDTH-1:0] imem_address_d;
  logic             misaligned_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, FIFO control and next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    squash_addr_d = squash_addr_q;
    push          = 1'b0;
    pop           = (count_q != '0) && ir_ready && !redirect;
    count_if_push = count_q + CW'(1) - CW'(pop);

`ifdef FETCH_ALIGN_CHECK_EN
    target_pc    = {redirect_pc[WIDTH-1:1], 1'b0};
    misaligned_d = redirect && redirect_pc[0];
`else
    target_pc    = redirect_pc;
    misaligned_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = target_pc;
        else if (count_q < CW'(DEPTH)) state_d = BUSY;
      end
      BUSY: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          if (imem_resp) begin
            state_d = IDLE;
          end else begin
            state_d       = SQUASH;
            squash_addr_d = fetch_pc_q;
          end
        end else if (imem_resp) begin
          push       = 1'b1;
          fetch_pc_d = WIDTH'(fetch_pc_q + WIDTH'(2));
          if (count_if_push >= CW'(DEPTH)) state_d = IDLE;
        end
      end
      SQUASH: begin
        // The stale read must still complete; a new redirect only retargets.
        if (redirect)  fetch_pc_d = target_pc;
        if (imem_resp) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d        = redirect ? '0 : (count_q + CW'(push) - CW'(pop));
    imem_read_d    = (state_d != IDLE);
    imem_address_d = (state_d == SQUASH) ? squash_addr_d : fetch_pc_d;
  end

  // Datapath, FIFO storage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      squash_addr_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      imem_read     <= 1'b0;
      imem_address  <= RESET_PC;
      misaligned    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      squash_addr_q <= squash_addr_d;
      count_q       <= count_d;
      imem_read     <= imem_read_d;
      imem_address  <= imem_address_d;
      misaligned    <= misaligned_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr_q]    <= fetch_pc_q;
          instr_mem[wr_ptr_q] <= imem_rdata;
          wr_ptr_q            <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign ir_valid = (count_q != '0);
  assign ir_out   = instr_mem[rd_ptr_q];
  assign ir_pc    = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, full FIFO, squashed read, redirects, wrap, alignment.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        misaligned;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 0;

  fetch_queue #(.WIDTH(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_out(ir_out), .ir_pc(ir_pc),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Memory: answers a held request after mem_lat extra cycles
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (imem_read && rst_n) begin
        if (wait_cnt >= mem_lat) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_word(imem_address);
          wait_cnt   = 0;
        end else begin
          imem_resp = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_resp = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_addr;
    rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_read",  32'(imem_read), 32'h0);
    check("rst_addr",  32'(imem_address), 32'h3000);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_out",   32'(ir_out), 32'h0);
    check("rst_pc",    32'(ir_pc), 32'h0);
    check("rst_mis",   32'(misaligned), 32'h0);
    rst_n = 1'b1;

    // Streaming with single-cycle memory and ir_ready=1
    @(negedge clk);
    check("s_read1",  32'(imem_read), 32'h1);
    check("s_addr1",  32'(imem_address), 32'h3000);
    check("s_valid1", 32'(ir_valid), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("s_addr",  32'(imem_address), 32'h3000 + 32'(2 * k));
      check("s_valid", 32'(ir_valid), 32'h1);
      check("s_pc",    32'(ir_pc), 32'h3000 + 32'(2 * (k - 1)));
      check("s_out",   32'(ir_out), 32'(mem_word(16'(16'h3000 + 2 * (k - 1)))));
    end

    // Fill with ir_ready=0: four pushes, then requests stop
    rst_n = 1'b0; ir_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check("f_read", 32'(imem_read), 32'h1);
      check("f_addr", 32'(imem_address), 32'h3000 + 32'(2 * (n - 1)));
    end
    @(negedge clk);
    check("f_full_read",  32'(imem_read), 32'h0);
    check("f_full_valid", 32'(ir_valid), 32'h1);
    check("f_full_pc",    32'(ir_pc), 32'h3000);
    @(negedge clk);
    check("f_full_read2", 32'(imem_read), 32'h0);
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    check("f_pop_pc",   32'(ir_pc), 32'h3002);
    check("f_pop_read", 32'(imem_read), 32'h0);
    @(negedge clk);
    check("f_refill_read", 32'(imem_read), 32'h1);
    check("f_refill_addr", 32'(imem_address), 32'h3008);
    @(negedge clk);
    check("f_refull_read", 32'(imem_read), 32'h0);
    check("f_refull_pc",   32'(ir_pc), 32'h3002);

    // Slow memory, redirect in cycle 2 squashes the 0x3000 read
    rst_n = 1'b0; ir_ready = 1'b1; mem_lat = 5;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("q_addr1", 32'(imem_address), 32'h3000);
    @(negedge clk);
    check("q_addr2", 32'(imem_address), 32'h3000);
    redirect = 1'b1; redirect_pc = 16'h4000;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      redirect = 1'b0;
      check("q_hold_read",  32'(imem_read), 32'h1);
      check("q_hold_addr",  32'(imem_address), 32'h3000);
      check("q_hold_valid", 32'(ir_valid), 32'h0);
    end
    @(negedge clk);
    mem_lat = 0;
    check("q_idle_read",  32'(imem_read), 32'h0);
    check("q_idle_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("q_new_read", 32'(imem_read), 32'h1);
    check("q_new_addr", 32'(imem_address), 32'h4000);
    @(negedge clk);
    check("q_first_valid", 32'(ir_valid), 32'h1);
    check("q_first_pc",    32'(ir_pc), 32'h4000);
    check("q_first_out",   32'(ir_out), 32'(mem_word(16'h4000)));

    // Redirect together with resp, push and pop
    redirect = 1'b1; redirect_pc = 16'h5000;
    @(negedge clk);
    redirect = 1'b0;
    check("r_flush_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("r_addr",  32'(imem_address), 32'h5000);
    check("r_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("r_pc", 32'(ir_pc), 32'h5000);

    // Address wrap at the top of the space
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    @(negedge clk);
    redirect = 1'b0;
    check("w_flush_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("w_addr0", 32'(imem_address), 32'hFFFC);
    @(negedge clk);
    check("w_addr1", 32'(imem_address), 32'hFFFE);
    check("w_pc1",   32'(ir_pc), 32'hFFFC);
    @(negedge clk);
    check("w_addr2", 32'(imem_address), 32'h0000);
    check("w_pc2",   32'(ir_pc), 32'hFFFE);
    check("w_out2",  32'(ir_out), 32'(mem_word(16'hFFFE)));

    // Odd redirect target
    redirect = 1'b1; redirect_pc = 16'h4001;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_addr = 16'h4000;
`else
    exp_addr = 16'h4001;
`endif
    @(negedge clk);
    redirect = 1'b0;
    check("a_valid", 32'(ir_valid), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("a_mis_pulse", 32'(misaligned), 32'h1);
`else
    check("a_mis_pulse", 32'(misaligned), 32'h0);
`endif
    @(negedge clk);
    check("a_read",    32'(imem_read), 32'h1);
    check("a_addr",    32'(imem_address), 32'(exp_addr));
    check("a_mis_end", 32'(misaligned), 32'h0);
    @(negedge clk);
    check("a_pc", 32'(ir_pc), 32'(exp_addr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
